// File: rtl/xmit_pkg.sv
// Shared definitions for the transmit frame feeder.
//   - FSM state encoding
//   - control-block field positions (length and its integrity copy)
//   - default frame-size limits
//   - saturating counter helper
package xmit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_CTRL = 2'd2,
    ST_SEND = 2'd3
  } xmit_state_e;

  localparam int LEN_HI_MSB = 23;
  localparam int LEN_HI_LSB = 12;
  localparam int LEN_LO_MSB = 11;
  localparam int LEN_LO_LSB = 0;
  localparam int LEN_W      = 12;

  localparam int DEF_MIN_LEN     = 64;
  localparam int DEF_MAX_LEN     = 2048;
  localparam int DEF_CTRL_CYCLES = 2;

  // Add n (0..2) to a 16-bit event counter, sticking at all-ones.
  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] n);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, n};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/xmit_frame_ram.sv
// Frame buffer: simple dual-port synchronous RAM, DEPTH x 8.
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr         : read request, data on o_rdata one cycle later
//   o_rdata              : registered read data; holds when no read is issued
// The read register is reset so the egress byte reads 0 out of reset.
module xmit_frame_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/xmit_frame_feeder.sv
// Store-and-forward feeder ahead of the transmit top level.
// Buffers one ingress frame (SOF/EOF byte stream), drops runt/oversize/
// malformed frames, then presents a length control block for CTRL_CYCLES
// cycles followed by the buffered bytes back to back.
//   clk_sys, reset_n          : clock, async active-low reset
//   in_data/valid/sof/eof     : ingress byte stream, in_ready is the accept
//   in_hi_priority            : frame priority, taken with the SOF byte
//   m_discard_en              : transmitter abandons the frame in flight
//   f_data_in/f_rec_data_valid: egress bytes
//   f_ctrl_in/f_rec_frame_valid: {len, len} control block
//   f_hi_priority             : priority of the frame in flight
//   frame_cnt/drop_cnt        : saturating forwarded / dropped counters
module xmit_frame_feeder
  import xmit_pkg::*;
#(
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int MIN_LEN     = DEF_MIN_LEN,
  parameter int CTRL_CYCLES = DEF_CTRL_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_hi_priority,
  output logic        in_ready,
  input  logic        m_discard_en,
  output logic [7:0]  f_data_in,
  output logic        f_rec_data_valid,
  output logic [23:0] f_ctrl_in,
  output logic        f_rec_frame_valid,
  output logic        f_hi_priority,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int PW = AW + 1;
  localparam int CW = (CTRL_CYCLES > 1) ? $clog2(CTRL_CYCLES) : 1;
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_LEN);
  localparam logic [PW-1:0] MIN_P   = PW'(MIN_LEN);
  localparam logic [CW-1:0] CC_LAST = CW'(CTRL_CYCLES - 1);

  xmit_state_e   r_state, w_next;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_len;
  logic          r_ovf, r_prio;
  logic [CW-1:0] r_cc;
  logic [23:0]   r_ctrl;
  logic [15:0]   r_frame_cnt, r_drop_cnt;

  logic          w_acc, w_at_max, w_last;
  logic [PW-1:0] w_len, w_rd_nxt;
  logic          w_we, w_re, w_start, w_adv, w_set_ovf, w_go_ctrl, w_frame_inc;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [1:0]    w_drop_n;
  logic [LEN_W-1:0] w_len12;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_FILL);
  assign w_acc    = in_valid && in_ready;
  // Buffer already full: any further byte means the frame is oversize.
  assign w_at_max = (r_wr_ptr == MAX_P);
  assign w_len    = w_at_max ? MAX_P : (r_wr_ptr + 1'b1);
  assign w_len12  = LEN_W'(w_len);
  assign w_rd_nxt = r_rd_ptr + 1'b1;
  assign w_last   = (r_rd_ptr == (r_len - 1'b1));

  always_comb begin
    w_next      = r_state;
    w_we        = 1'b0;
    w_waddr     = r_wr_ptr[AW-1:0];
    w_re        = 1'b0;
    w_raddr     = '0;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_set_ovf   = 1'b0;
    w_go_ctrl   = 1'b0;
    w_drop_n    = 2'd0;
    w_frame_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && in_sof) begin
          w_we    = 1'b1;
          w_waddr = '0;
          if (in_eof) w_drop_n = 2'd1;   // single-byte frame is always a runt
          else begin
            w_start = 1'b1;
            w_next  = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (w_acc) begin
          if (in_sof) begin
            // EOF never came: abandon the pending frame, restart at address 0.
            w_we     = 1'b1;
            w_waddr  = '0;
            w_drop_n = 2'd1;
            if (in_eof) begin
              w_drop_n = 2'd2;
              w_next   = ST_IDLE;
            end else begin
              w_start = 1'b1;
            end
          end else begin
            if (w_at_max) w_set_ovf = 1'b1;
            else begin
              w_we  = 1'b1;
              w_adv = 1'b1;
            end
            if (in_eof) begin
              if (r_ovf || w_at_max || (w_len < MIN_P)) begin
                w_drop_n = 2'd1;
                w_next   = ST_IDLE;
              end else begin
                w_go_ctrl = 1'b1;
                w_next    = ST_CTRL;
              end
            end
          end
        end
      end
      ST_CTRL: begin
        if (m_discard_en) begin
          w_drop_n = 2'd1;
          w_next   = ST_IDLE;
        end else if (r_cc == CC_LAST) begin
          // Prefetch byte 0 so it is on f_data_in in the first SEND cycle.
          w_re    = 1'b1;
          w_raddr = '0;
          w_next  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_discard_en) begin
          w_drop_n = 2'd1;
          w_next   = ST_IDLE;
        end else if (w_last) begin
          w_frame_inc = 1'b1;
          w_next      = ST_IDLE;
        end else begin
          w_re    = 1'b1;
          w_raddr = w_rd_nxt[AW-1:0];
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      r_prio      <= 1'b0;
      r_cc        <= '0;
      r_ctrl      <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_wr_ptr <= PW'(1);
        r_prio   <= in_hi_priority;
        r_ovf    <= 1'b0;
      end else if (w_adv) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_go_ctrl) begin
        r_len                         <= w_len;
        r_ctrl[LEN_HI_MSB:LEN_HI_LSB] <= w_len12;
        r_ctrl[LEN_LO_MSB:LEN_LO_LSB] <= w_len12;
        r_cc                          <= '0;
      end
      if (r_state == ST_CTRL) begin
        r_cc     <= r_cc + 1'b1;
        r_rd_ptr <= '0;
      end
      if (r_state == ST_SEND) r_rd_ptr <= w_rd_nxt;
      if (w_drop_n != 2'd0) r_drop_cnt  <= sat_add(r_drop_cnt, w_drop_n);
      if (w_frame_inc)      r_frame_cnt <= sat_add(r_frame_cnt, 2'd1);
    end
  end

  xmit_frame_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (f_data_in)
  );

  assign f_ctrl_in         = r_ctrl;
  assign f_rec_frame_valid = (r_state == ST_CTRL);
  assign f_rec_data_valid  = (r_state == ST_SEND);
  assign f_hi_priority     = ((r_state == ST_CTRL) || (r_state == ST_SEND)) && r_prio;
  assign frame_cnt         = r_frame_cnt;
  assign drop_cnt          = r_drop_cnt;

endmodule

// File: tb/tb_xmit_frame_feeder.sv
// Directed + randomized bench for xmit_frame_feeder with a frame-level
// reference model (length rules only) and an output monitor.
module tb_xmit_frame_feeder;

  localparam int MAX_LEN     = 2048;
  localparam int MIN_LEN     = 64;
  localparam int CTRL_CYCLES = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_hi_priority = 1'b0;
  logic        in_ready;
  logic        m_discard_en = 1'b0;
  logic [7:0]  f_data_in;
  logic        f_rec_data_valid, f_rec_frame_valid, f_hi_priority;
  logic [23:0] f_ctrl_in;
  logic [15:0] frame_cnt, drop_cnt;

  always #5 clk_sys = ~clk_sys;

  xmit_frame_feeder #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .CTRL_CYCLES(CTRL_CYCLES)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_hi_priority(in_hi_priority), .in_ready(in_ready), .m_discard_en(m_discard_en),
    .f_data_in(f_data_in), .f_rec_data_valid(f_rec_data_valid), .f_ctrl_in(f_ctrl_in),
    .f_rec_frame_valid(f_rec_frame_valid), .f_hi_priority(f_hi_priority),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0, n_err = 0;

  // Reference model state
  int           exp_frame = 0, exp_drop = 0;
  bit           pending = 1'b0;
  logic [23:0]  exp_ctrl_q[$];
  bit           exp_prio_q[$];
  int           exp_len_q[$];
  byte unsigned exp_bytes[$];

  // Monitor state
  logic [23:0]  mon_ctrl_q[$];
  int           mon_ccyc_q[$];
  bit           mon_prio_q[$];
  int           mon_dlen_q[$];
  byte unsigned mon_bytes[$];
  int  rdy_err = 0, prio_err = 0, gap_err = 0;
  logic prev_fv = 1'b0, prev_dv = 1'b0, cur_prio = 1'b0;
  int  cur_cc = 0, cur_dl = 0;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_fv <= 1'b0;
      prev_dv <= 1'b0;
    end else begin
      prev_fv <= f_rec_frame_valid;
      prev_dv <= f_rec_data_valid;
      if ((f_rec_frame_valid || f_rec_data_valid) && in_ready) rdy_err <= rdy_err + 1;
      if (f_rec_frame_valid && f_rec_data_valid) gap_err <= gap_err + 1;
      if (prev_fv && !f_rec_frame_valid && !f_rec_data_valid) gap_err <= gap_err + 1;
      if (f_rec_data_valid && !prev_dv && !prev_fv) gap_err <= gap_err + 1;
      if (f_rec_frame_valid && !prev_fv) begin
        mon_ctrl_q.push_back(f_ctrl_in);
        mon_prio_q.push_back(f_hi_priority);
        cur_prio <= f_hi_priority;
        cur_cc   <= 1;
      end else if (f_rec_frame_valid) begin
        cur_cc <= cur_cc + 1;
        if (f_hi_priority !== cur_prio) prio_err <= prio_err + 1;
      end
      if (!f_rec_frame_valid && prev_fv) mon_ccyc_q.push_back(cur_cc);
      if (f_rec_data_valid) begin
        mon_bytes.push_back(f_data_in);
        cur_dl <= prev_dv ? cur_dl + 1 : 1;
        if (f_hi_priority !== cur_prio) prio_err <= prio_err + 1;
      end
      if (!f_rec_data_valid && prev_dv) mon_dlen_q.push_back(cur_dl);
      if (!f_rec_frame_valid && !f_rec_data_valid && f_hi_priority) prio_err <= prio_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a terminated frame is forwarded iff MIN_LEN <= len <= MAX_LEN.
  task automatic model_frame(input byte unsigned q[$], input bit pr);
    int len = q.size();
    if (len < MIN_LEN || len > MAX_LEN) exp_drop++;
    else begin
      exp_frame++;
      exp_ctrl_q.push_back({12'(len), 12'(len)});
      exp_prio_q.push_back(pr);
      exp_len_q.push_back(len);
      foreach (q[i]) exp_bytes.push_back(q[i]);
    end
  endtask

  // Model: the transmitter abandoned the most recent forwarded frame.
  task automatic model_discard();
    int len = exp_len_q.pop_back();
    void'(exp_ctrl_q.pop_back());
    void'(exp_prio_q.pop_back());
    repeat (len) void'(exp_bytes.pop_back());
    exp_frame--;
    exp_drop++;
  endtask

  task automatic push_byte(input byte unsigned d, input bit sof, input bit eof, input bit pr);
    int g = 0;
    in_data = d; in_sof = sof; in_eof = eof; in_hi_priority = pr; in_valid = 1'b1;
    while (!in_ready && g < 10000) begin @(negedge clk_sys); g++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk_sys);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  // mode 0: constant fill byte, otherwise random bytes
  task automatic send_frame(input int len, input int mode, input byte unsigned fill,
                            input bit pr, input bit gaps, input bit with_eof);
    byte unsigned q[$];
    byte unsigned b;
    if (pending) begin exp_drop++; pending = 1'b0; end
    for (int i = 0; i < len; i++) begin
      b = (mode == 0) ? fill : 8'($urandom);
      q.push_back(b);
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk_sys);
      push_byte(b, i == 0, with_eof && (i == len - 1), pr);
    end
    if (with_eof) model_frame(q, pr);
    else pending = 1'b1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(in_ready && !f_rec_frame_valid && !f_rec_data_valid) && g < 6000) begin
      @(negedge clk_sys); g++;
    end
    if (g >= 6000) chk("idle_timeout", 32'(in_ready), 32'd1);
    @(negedge clk_sys);
  endtask

  task automatic clear_queues();
    mon_ctrl_q.delete(); mon_ccyc_q.delete(); mon_prio_q.delete();
    mon_dlen_q.delete(); mon_bytes.delete();
    exp_ctrl_q.delete(); exp_prio_q.delete(); exp_len_q.delete(); exp_bytes.delete();
  endtask

  task automatic check_frames(input string tag);
    int n, bad;
    chk({tag, ".n_ctrl"}, 32'(mon_ctrl_q.size()), 32'(exp_ctrl_q.size()));
    chk({tag, ".n_data"}, 32'(mon_dlen_q.size()), 32'(exp_len_q.size()));
    chk({tag, ".n_bytes"}, 32'(mon_bytes.size()), 32'(exp_bytes.size()));
    n = (mon_ctrl_q.size() < exp_ctrl_q.size()) ? mon_ctrl_q.size() : exp_ctrl_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.ctrl[%0d]", tag, i), 32'(mon_ctrl_q[i]), 32'(exp_ctrl_q[i]));
      chk($sformatf("%s.prio[%0d]", tag, i), 32'(mon_prio_q[i]), 32'(exp_prio_q[i]));
      if (i < mon_ccyc_q.size())
        chk($sformatf("%s.ctrl_cycles[%0d]", tag, i), 32'(mon_ccyc_q[i]), 32'(CTRL_CYCLES));
      if (i < mon_dlen_q.size())
        chk($sformatf("%s.dlen[%0d]", tag, i), 32'(mon_dlen_q[i]), 32'(exp_len_q[i]));
    end
    bad = 0;
    n = (mon_bytes.size() < exp_bytes.size()) ? mon_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) if (mon_bytes[i] !== exp_bytes[i]) bad++;
    chk({tag, ".byte_errors"}, 32'(bad), 32'd0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_frame));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    chk({tag, ".ready_in_ctrl_send"}, 32'(rdy_err), 32'd0);
    chk({tag, ".prio_err"}, 32'(prio_err), 32'd0);
    chk({tag, ".stream_gap_err"}, 32'(gap_err), 32'd0);
    clear_queues();
  endtask

  initial begin
    int n, g, len;
    bit pr;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.frame_valid", 32'(f_rec_frame_valid), 32'd0);
    chk("rst.data_valid", 32'(f_rec_data_valid), 32'd0);
    chk("rst.ctrl", 32'(f_ctrl_in), 32'd0);
    chk("rst.data", 32'(f_data_in), 32'd0);
    chk("rst.prio", 32'(f_hi_priority), 32'd0);
    chk("rst.frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // 512-byte 0xCC high priority
    send_frame(512, 0, 8'hCC, 1'b1, 1'b0, 1'b1);
    wait_idle();
    chk("f512.ctrl_literal", 32'(f_ctrl_in), 32'h200200);
    chk("f512.data_hold", 32'(f_data_in), 32'hCC);
    chk("f512.prio_idle", 32'(f_hi_priority), 32'd0);
    check_frames("f512");

    // Back-to-back 64 x 0xAA then 100 x 0x11
    send_frame(64, 0, 8'hAA, 1'b0, 1'b0, 1'b1);
    send_frame(100, 0, 8'h11, 1'b1, 1'b0, 1'b1);
    wait_idle();
    chk("b2b.ctrl_literal", 32'(f_ctrl_in), 32'h064064);
    check_frames("b2b");

    // Runt and oversize drops
    send_frame(63, 1, 8'h00, 1'b0, 1'b1, 1'b1);
    wait_idle();
    chk("runt.drop_cnt", 32'(drop_cnt), 32'd1);
    send_frame(2100, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    chk("ovs.drop_cnt", 32'(drop_cnt), 32'd2);
    check_frames("drops");

    // Missing EOF: SOF of a new frame arrives after 10 bytes
    send_frame(10, 1, 8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(64, 1, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk("resof.ctrl_literal", 32'(f_ctrl_in), 32'h040040);
    check_frames("resof");

    // Boundary lengths around MAX_LEN and MIN_LEN
    send_frame(MAX_LEN, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    send_frame(MAX_LEN + 1, 1, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_idle();
    send_frame(1, 1, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_idle();
    send_frame(MIN_LEN, 1, 8'h00, 1'b1, 1'b1, 1'b1);
    wait_idle();
    check_frames("bound");

    // Randomized frames with ingress bubbles
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(MIN_LEN - 3, MIN_LEN + 3);
        1:       len = $urandom_range(MIN_LEN + 1, 400);
        default: len = $urandom_range(2, 80);
      endcase
      pr = 1'($urandom);
      send_frame(len, 1, 8'h00, pr, 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    check_frames("rand");

    // Discard at SEND byte 5 of a 128-byte frame
    send_frame(128, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    model_discard();
    n = 0; g = 0;
    while (n < 5 && g < 200) begin
      @(negedge clk_sys); g++;
      if (f_rec_data_valid) n++;
    end
    chk("disc.reached_byte5", 32'(n), 32'd5);
    m_discard_en = 1'b1;
    @(negedge clk_sys);
    m_discard_en = 1'b0;
    chk("disc.data_valid", 32'(f_rec_data_valid), 32'd0);
    chk("disc.drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("disc.frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    @(negedge clk_sys);
    chk("disc.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk_sys);
    mon_ctrl_q.delete(); mon_ccyc_q.delete(); mon_prio_q.delete();
    mon_dlen_q.delete(); mon_bytes.delete();
    check_frames("disc");

    // Reset mid-SEND, then a fresh frame
    send_frame(200, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    n = 0; g = 0;
    while (n < 20 && g < 400) begin
      @(negedge clk_sys); g++;
      if (f_rec_data_valid) n++;
    end
    reset_n = 1'b0;
    #1;
    chk("rst2.data_valid", 32'(f_rec_data_valid), 32'd0);
    chk("rst2.frame_valid", 32'(f_rec_frame_valid), 32'd0);
    chk("rst2.ctrl", 32'(f_ctrl_in), 32'd0);
    chk("rst2.data", 32'(f_data_in), 32'd0);
    chk("rst2.prio", 32'(f_hi_priority), 32'd0);
    chk("rst2.frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst2.drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst2.in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    clear_queues();
    exp_frame = 0; exp_drop = 0; pending = 1'b0;
    @(negedge clk_sys);
    send_frame(64, 1, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_idle();
    check_frames("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xmit_frame_feeder.md
Name: xmit_frame_feeder

Overview:
- Store-and-forward feeder directly upstream of the transmit top level.
- Accepts one ingress frame as a byte stream with SOF/EOF markers and buffers the whole frame.
- Once the frame length is known, presents a 24-bit control block, then streams the buffered bytes on the transmit side's f_* inputs.
- Drops runt, oversize and malformed frames before they reach the transmitter.

Parameters:
- MAX_LEN, 2048, buffer depth and largest accepted frame in bytes (power of 2, ≤4095).
- MIN_LEN, 64, smallest accepted frame in bytes.
- CTRL_CYCLES, 2, cycles f_rec_frame_valid is held per frame (≥1).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ingress byte.
- in_valid  in  1  in_data valid this cycle.
- in_sof  in  1  first byte of frame (qualified by in_valid).
- in_eof  in  1  last byte of frame (qualified by in_valid).
- in_hi_priority  in  1  frame priority, sampled with the SOF byte.
- in_ready  out  1  feeder accepts a byte this cycle.
- m_discard_en  in  1  transmitter discarded the current frame.
- f_data_in  out  8  egress byte.
- f_rec_data_valid  out  1  f_data_in valid.
- f_ctrl_in  out  24  control block: [23:12] = frame length in bytes, [11:0] = same length (integrity copy).
- f_rec_frame_valid  out  1  f_ctrl_in valid.
- f_hi_priority  out  1  latched priority of the frame in flight.
- frame_cnt  out  16  frames forwarded, saturating.
- drop_cnt  out  16  frames dropped or discarded, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - All outputs are 0, except in_ready, which is 1 once in IDLE.
  - Pointers, flags and counters are cleared.
  - Reset mid-frame abandons the frame silently; drop_cnt is not incremented.
- FSM states: IDLE, FILL, CTRL, SEND.
- in_ready is 1 in IDLE and FILL, 0 in CTRL and SEND. A byte is accepted only when in_valid and in_ready are both 1.
- IDLE:
  - Accepted byte without in_sof is ignored.
  - Accepted SOF byte: write to address 0, wr_ptr=1, latch in_hi_priority, go to FILL.
  - Accepted SOF byte with in_eof also set: length 1 < MIN_LEN, so drop_cnt+1 and stay in IDLE.
- FILL:
  - Each accepted byte is written at wr_ptr, then wr_ptr increments.
  - If wr_ptr reaches MAX_LEN, further writes are suppressed and the ovf flag is set.
  - Accepted byte with in_sof (EOF missing): the current frame is dropped (drop_cnt+1) and the byte restarts a new frame at address 0 with a new priority latch. State stays FILL.
  - Accepted byte with in_eof: len = wr_ptr+1 (capped at MAX_LEN).
    - If ovf, or len < MIN_LEN: drop_cnt+1, go to IDLE.
    - Otherwise: go to CTRL.
- CTRL:
  - f_ctrl_in = {len[11:0], len[11:0]}.
  - f_rec_frame_valid = 1 for exactly CTRL_CYCLES cycles.
  - f_hi_priority is driven with the latched value from entry to CTRL until SEND ends.
  - RAM read of address 0 is issued in the last CTRL cycle, so data is ready on the first SEND cycle.
  - Then go to SEND.
- SEND:
  - One byte per cycle, no gaps: f_data_in = mem[rd_ptr], f_rec_data_valid = 1, for len consecutive cycles.
  - After the last byte: frame_cnt+1, go to IDLE. f_rec_data_valid drops the following cycle.
  - First ingress byte of the next frame can be accepted the cycle after SEND ends.
- m_discard_en:
  - Sampled in CTRL or SEND; if 1, remaining bytes are abandoned next cycle, f_rec_data_valid=0, drop_cnt+1, go to IDLE.
  - If asserted on the cycle of the last byte, discard takes priority: drop_cnt+1, frame_cnt unchanged.
  - Ignored in IDLE and FILL.
- Output hold rules:
  - f_ctrl_in and f_data_in hold their last values when not valid.
  - f_hi_priority returns to 0 in IDLE.
- Arithmetic:
  - Pointers are clog2(MAX_LEN)+1 bits; length field is 12 bits.
  - Counters saturate at 16'hFFFF.

Decomposition:
- Shared package xmit_pkg holds:
  - FSM state enum.
  - Control-block field positions (LEN_HI 23:12, LEN_LO 11:0).
  - Default MIN_LEN and MAX_LEN constants.
- One sub-module: xmit_frame_ram, a simple dual-port synchronous RAM (1 write port, 1 read port, 1-cycle read latency, MAX_LEN x 8).

Test Plan:
- 512-byte frame of 0xCC, in_hi_priority=1:
  - f_ctrl_in=24'h200200 with f_rec_frame_valid high for 2 cycles.
  - Then 512 consecutive f_rec_data_valid cycles carrying 0xCC, with f_hi_priority=1 throughout.
  - frame_cnt=1.
- Back-to-back frames 0xAA (64 B) then 0x11 (100 B):
  - in_ready=0 throughout CTRL/SEND.
  - Second frame's ctrl block 24'h064064 appears only after the first frame's 64th byte.
- 63-byte frame: no f_rec_frame_valid, drop_cnt=1. Oversize frame of 2100 bytes: no f_rec_frame_valid, drop_cnt=2.
- SOF at byte 10 of a pending frame, followed by a 64-byte frame ending in EOF: drop_cnt+1, and only the 64-byte frame is forwarded (ctrl 24'h040040).
- m_discard_en pulsed at SEND byte 5 of a 128-byte frame:
  - f_rec_data_valid falls the next cycle.
  - drop_cnt+1, frame_cnt unchanged.
  - in_ready=1 the cycle after that.
- reset_n asserted low mid-SEND: all outputs go to 0 immediately. After release, a fresh 64-byte frame forwards correctly with counters starting from 0.
